bird_drawer: RTL and testbench
==============================

BIRD_DRAWER -- requirements
Module: bird_drawer

Interface
REQ-001 Parameter SPRITE_W, default 4, sprite width in pixels (1..8).
REQ-002 Parameter SPRITE_H, default 4, sprite height in pixels (1..8).
REQ-003 Parameter BG_COLOUR, default 3'b000, erase colour.
REQ-004 Parameter FG_COLOUR, default 3'b110, bird colour.
REQ-005 clock  input  1  system clock (CLOCK_50); all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 frame_tick  input  1  one-cycle pulse, start of a redraw frame.
REQ-008 bird_x  input  8  bird top-left x from bird position stage, sampled on accepted frame_tick.
REQ-009 bird_y  input  7  bird top-left y, sampled on accepted frame_tick.
REQ-010 visible  input  1  1 = draw bird this frame, 0 = erase only; sampled on accepted frame_tick.
REQ-011 x_out  output  8  pixel x to vga_adapter.
REQ-012 y_out  output  7  pixel y to vga_adapter.
REQ-013 colour  output  3  pixel colour {R,G,B}.
REQ-014 plot  output  1  write strobe; x_out/y_out/colour valid while high.
REQ-015 busy  output  1  high while any frame is being processed.
REQ-016 done  output  1  one-cycle pulse at end of frame.
REQ-017 overrun  output  1  sticky; set when frame_tick arrives while busy.

Function
REQ-018 FSM states IDLE, ERASE, DRAW, FINISH; exactly one active.
REQ-019 IDLE + frame_tick: latch bird_x/bird_y/visible into new_x/new_y/new_vis; go ERASE if drawn_flag=1, else DRAW if new_vis=1, else FINISH.
REQ-020 ERASE: one pixel per cycle at (old_x+col, old_y+row), colour=BG_COLOUR, row-major, col fastest; SPRITE_W*SPRITE_H cycles.
REQ-021 After last ERASE pixel: DRAW if new_vis=1, else FINISH.
REQ-022 DRAW: same scan at (new_x+col, new_y+row), colour=FG_COLOUR; SPRITE_W*SPRITE_H cycles; then FINISH.
REQ-023 FINISH (one cycle): done=1; old_x/old_y <= new_x/new_y; drawn_flag <= new_vis; return IDLE.
REQ-024 Outputs registered: pixel for scan index k issued k+1 cycles after entering ERASE/DRAW; first plot cycle directly follows the frame_tick cycle.
REQ-025 Coordinate sums computed 9-bit (x) / 8-bit (y); pixel with x>=160 or y>=120 SHALL have plot=0 but still consumes its cycle (clipping, no wrap-around).
REQ-026 busy=1 in every state except IDLE; busy falls the cycle after done.
REQ-027 frame_tick while busy (including FINISH cycle) is ignored, inputs not sampled, overrun <= 1; overrun cleared only by reset.
REQ-028 frame_tick in IDLE always accepted; back-to-back frames allowed with one IDLE cycle between done and next tick.
REQ-029 plot=0 in IDLE and FINISH; colour/x_out/y_out hold last value when plot=0.
REQ-030 Total frame length: 1 + E + D cycles from tick to done, E,D each 0 or SPRITE_W*SPRITE_H.

Reset
REQ-031 reset low: state=IDLE, x_out=0, y_out=0, colour=0, plot=0, busy=0, done=0, overrun=0, drawn_flag=0, old_x=0, old_y=0, counters=0, immediately (asynchronous).
REQ-032 Reset mid-ERASE/DRAW aborts scan with no further plot; first frame after reset performs no ERASE.

Verification
REQ-033 After reset, tick with (10,20), visible=1 -> 16 plots colour 3'b110, (10,20)..(13,23) row-major, first plot next cycle, done 17 cycles after tick.
REQ-034 Second tick with (30,40), visible=1 -> 16 plots 3'b000 at (10,20)..(13,23), then 16 plots 3'b110 at (30,40)..(33,43), done 33 cycles after tick.
REQ-035 Tick with (158,118), visible=1 -> only (158,118),(159,118),(158,119),(159,119) plotted; 12 cycles plot=0; busy for full 16.
REQ-036 Tick with visible=0 after drawn bird -> erase only, 16 plots 3'b000, no FG pixels; next tick performs no ERASE.
REQ-037 Tick asserted during DRAW -> overrun=1, scan unaffected; overrun stays 1 until reset.
REQ-038 reset asserted mid-DRAW -> plot=0 same cycle, busy=0; next tick draws without erase.

Source files
------------

// File: rtl/bird_drawer.sv
// rtl/bird_drawer.sv - erases the previous bird sprite and draws the new one, one pixel per clock
module bird_drawer #(
    parameter int          SPRITE_W  = 4,
    parameter int          SPRITE_H  = 4,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter logic [2:0]  FG_COLOUR = 3'b110
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] bird_x,
    input  logic [6:0] bird_y,
    input  logic       visible,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    localparam logic [2:0] COL_LAST = 3'(SPRITE_W - 1);
    localparam logic [2:0] ROW_LAST = 3'(SPRITE_H - 1);

    state_t     state;
    logic [7:0] new_x, old_x;
    logic [6:0] new_y, old_y;
    logic       new_vis, drawn_flag;
    logic [2:0] col, row;
    logic       scan_end;

    // Pixel to issue on the coming edge; the first pixel of a phase is chosen
    // one cycle early so that plots run back-to-back across phase changes.
    logic       pix_en, pix_fg;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] pix_col, pix_row;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       on_screen, pix_last;
    logic [2:0] next_col, next_row;

    always_comb begin
        pix_en  = 1'b0;
        pix_fg  = 1'b0;
        base_x  = new_x;
        base_y  = new_y;
        pix_col = col;
        pix_row = row;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    pix_col = 3'd0;
                    pix_row = 3'd0;
                    if (drawn_flag) begin
                        pix_en = 1'b1;
                        base_x = old_x;
                        base_y = old_y;
                    end else if (visible) begin
                        pix_en = 1'b1;
                        pix_fg = 1'b1;
                        base_x = bird_x;
                        base_y = bird_y;
                    end
                end
            end
            ERASE: begin
                if (!scan_end) begin
                    pix_en = 1'b1;
                    base_x = old_x;
                    base_y = old_y;
                end else if (new_vis) begin
                    pix_en  = 1'b1;
                    pix_fg  = 1'b1;
                    pix_col = 3'd0;
                    pix_row = 3'd0;
                end
            end
            DRAW: begin
                if (!scan_end) begin
                    pix_en = 1'b1;
                    pix_fg = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sums are one bit wider than the coordinates so off-screen pixels clip rather than wrap.
    assign sum_x     = {1'b0, base_x} + {6'd0, pix_col};
    assign sum_y     = {1'b0, base_y} + {5'd0, pix_row};
    assign on_screen = (sum_x < 9'd160) && (sum_y < 8'd120);
    assign pix_last  = (pix_col == COL_LAST) && (pix_row == ROW_LAST);

    always_comb begin
        next_col = pix_col + 3'd1;
        next_row = pix_row;
        if (pix_col == COL_LAST) begin
            next_col = 3'd0;
            next_row = (pix_row == ROW_LAST) ? 3'd0 : pix_row + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            colour     <= 3'd0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            new_x      <= 8'd0;
            new_y      <= 7'd0;
            new_vis    <= 1'b0;
            old_x      <= 8'd0;
            old_y      <= 7'd0;
            drawn_flag <= 1'b0;
            col        <= 3'd0;
            row        <= 3'd0;
            scan_end   <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (pix_en) begin
                if (on_screen) begin
                    x_out  <= sum_x[7:0];
                    y_out  <= sum_y[6:0];
                    colour <= pix_fg ? FG_COLOUR : BG_COLOUR;
                    plot   <= 1'b1;
                end
                col      <= next_col;
                row      <= next_row;
                scan_end <= pix_last;
            end
            if (frame_tick && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        new_x   <= bird_x;
                        new_y   <= bird_y;
                        new_vis <= visible;
                        busy    <= 1'b1;
                        if (drawn_flag)
                            state <= ERASE;
                        else if (visible)
                            state <= DRAW;
                        else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                ERASE: begin
                    if (scan_end) begin
                        if (new_vis)
                            state <= DRAW;
                        else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (scan_end) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    old_x      <= new_x;
                    old_y      <= new_y;
                    drawn_flag <= new_vis;
                    scan_end   <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bird_drawer.sv
// tb/tb_bird_drawer.sv - scoreboard bench for bird_drawer
module tb_bird_drawer;

    localparam int N = 16;
    localparam logic [2:0] BG = 3'b000;
    localparam logic [2:0] FG = 3'b110;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] bird_x = 8'd0;
    logic [6:0] bird_y = 7'd0;
    logic       visible = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot, busy, done, overrun;

    bird_drawer dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .bird_x(bird_x), .bird_y(bird_y), .visible(visible),
        .x_out(x_out), .y_out(y_out), .colour(colour),
        .plot(plot), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int plot_cnt = 0;
    logic [17:0] sb[$];

    logic [7:0] m_old_x = 8'd0;
    logic [6:0] m_old_y = 7'd0;
    logic       m_drawn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected sprite scan: row-major, column fastest, off-screen pixels never plotted.
    task automatic push_scan(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (int'(bx) + k < 160 && int'(by) + r < 120)
                    sb.push_back({8'(int'(bx) + k), 7'(int'(by) + r), c});
    endtask

    always @(negedge clock) begin
        if (reset && plot) begin
            plot_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_plot: got (%0d,%0d,%b), expected no plot", x_out, y_out, colour);
            end else begin
                check("pixel", 32'({x_out, y_out, colour}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic run_frame(input logic [7:0] bx, input logic [6:0] by, input logic vis, input int ovr_at);
        int exp_len, n, exp_cnt;
        logic first_on;
        exp_len  = 1 + (m_drawn ? N : 0) + (vis ? N : 0);
        first_on = m_drawn ? (m_old_x < 160 && m_old_y < 120) : (vis && bx < 160 && by < 120);
        if (m_drawn) push_scan(m_old_x, m_old_y, BG);
        if (vis) push_scan(bx, by, FG);
        exp_cnt  = sb.size();
        plot_cnt = 0;
        @(posedge clock); #1;
        bird_x = bx; bird_y = by; visible = vis; frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        n = 1;
        check("first_plot", 32'(plot), 32'(exp_len > 1 && first_on));
        check("busy_in_frame", 32'(busy), 32'd1);
        while (!done && n < 200) begin
            if (n == ovr_at) begin
                frame_tick = 1'b1;
                bird_x = 8'hFF; bird_y = 7'h7F; visible = 1'b0;
            end else begin
                frame_tick = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        frame_tick = 1'b0;
        check("done_latency", 32'(n), 32'(exp_len));
        @(posedge clock); #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("plot_count", 32'(plot_cnt), 32'(exp_cnt));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        m_old_x = bx; m_old_y = by; m_drawn = vis;
    endtask

    initial begin
        #12;
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clock); reset = 1'b1;

        run_frame(8'd10, 7'd20, 1'b1, 0);
        run_frame(8'd30, 7'd40, 1'b1, 0);
        run_frame(8'd158, 7'd118, 1'b1, 0);
        run_frame(8'd70, 7'd50, 1'b1, 0);
        run_frame(8'd0, 7'd0, 1'b0, 0);
        run_frame(8'd5, 7'd5, 1'b0, 0);
        check("overrun_clear", 32'(overrun), 32'd0);
        run_frame(8'd20, 7'd30, 1'b1, 5);
        check("overrun_set", 32'(overrun), 32'd1);
        run_frame(8'd40, 7'd10, 1'b1, 0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        push_scan(8'd40, 7'd10, BG);
        push_scan(8'd90, 7'd90, FG);
        @(posedge clock); #1;
        bird_x = 8'd90; bird_y = 7'd90; visible = 1'b1; frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        check("mid_draw_plot", 32'(plot), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_plot", 32'(plot), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        check("rst_mid_x", 32'(x_out), 32'd0);
        sb.delete();
        m_drawn = 1'b0;
        @(negedge clock); reset = 1'b1;

        run_frame(8'd50, 7'd60, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
